// File: rtl/rtc_pkg.sv
// Shared BCD limits and helpers for the bcd_rtc_core real-time clock.
package rtc_pkg;

  localparam logic [7:0] SEC_MAX   = 8'h59;
  localparam logic [7:0] MIN_MAX   = 8'h59;
  localparam logic [7:0] HOUR_MAX  = 8'h23;
  localparam logic [7:0] HOUR_NOON = 8'h12;

  // Two-digit BCD value: both nibbles decimal and the whole value within lim.
  function automatic logic bcd_valid(input logic [7:0] v, input logic [7:0] lim);
    return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) && (v <= lim);
  endfunction

  // 24-hour BCD hour to 12-hour BCD display hour (00 shows as 12).
  function automatic logic [7:0] hour_to_12h(input logic [7:0] h24);
    logic [4:0] bin;
    if (h24 == 8'h00) return HOUR_NOON;
    if (h24 <= HOUR_NOON) return h24;
    bin = 5'(h24[7:4]) * 5'd10 + 5'(h24[3:0]) - 5'd12;
    if (bin >= 5'd10) return {4'd1, 4'(bin - 5'd10)};
    return {4'd0, bin[3:0]};
  endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD modulo counter (0..MAX) with validated load and a
// combinational wrap flag used to chain seconds -> minutes -> hours.
module bcd_mod_counter
  import rtc_pkg::*;
#(
  parameter logic [7:0] MAX = 8'h59
) (
  input  logic       clk1,
  input  logic       rst_n,
  input  logic       inc,
  input  logic       dec,
  input  logic       ld,
  input  logic [7:0] ld_val,
  output logic [7:0] value,
  output logic       wrap
);

  logic [7:0] r_value;
  logic [7:0] w_next;

  // High when the step requested this cycle rolls the field over.
  assign wrap  = (inc && (r_value == MAX)) || (dec && (r_value == 8'h00));
  assign value = r_value;

  // Next value: load (validated) beats increment beats decrement.
  always_comb begin
    // NOTE: default assignment first so every path drives w_next and no latch is inferred.
    w_next = r_value;
    if (ld) begin
      w_next = bcd_valid(ld_val, MAX) ? ld_val : 8'h00;
    end else if (inc) begin
      if (r_value == MAX)         w_next = 8'h00;
      else if (r_value[3:0] == 4'd9) w_next = {r_value[7:4] + 4'd1, 4'd0};
      else                        w_next = r_value + 8'd1;
    end else if (dec) begin
      if (r_value == 8'h00)       w_next = MAX;
      else if (r_value[3:0] == 4'd0) w_next = {r_value[7:4] - 4'd1, 4'd9};
      else                        w_next = r_value - 8'd1;
    end
  end

  // Field register with synchronous reset.
  always_ff @(posedge clk1) begin
    // NOTE: non-blocking assignment so all flops update together at the edge.
    if (!rst_n) r_value <= 8'h00;
    else        r_value <= w_next;
  end

endmodule

// File: rtl/bcd_rtc_core.sv
// BCD hh:mm:ss real-time core with seconds prescaler, up/down counting,
// 12/24-hour display formatting, validated field loads and day-carry pulse.
// Optional alarm (sticky flag, arm/ack) is built when RTC_ALARM_EN is defined.
module bcd_rtc_core
  import rtc_pkg::*;
#(
  parameter int CLK_DIV = 50000000,
  parameter int PS_W    = 26
) (
  input  logic        clk1,
  input  logic        rst_n,
  input  logic        CTT,
  input  logic        CTP,
  input  logic        dir,
  input  logic        mode_12h,
  input  logic [7:0]  hour_in,
  input  logic [7:0]  min_in,
  input  logic [7:0]  sec_in,
  input  logic        hour_ld,
  input  logic        min_ld,
  input  logic        sec_ld,
`ifdef RTC_ALARM_EN
  input  logic [23:0] alarm_in,
  input  logic        alarm_set,
  input  logic        alarm_arm,
  input  logic        alarm_ack,
  output logic        alarm_o,
`endif
  output logic [23:0] num,
  output logic        pm,
  output logic        tick,
  output logic        day_carry
);

  logic [PS_W-1:0] r_ps;
  logic            r_tick;
  logic            r_day_carry;
  logic            w_any_ld;
  logic            w_en;
  logic            w_step;
  logic            w_up;
  logic            w_dn;
  logic [7:0]      w_sec;
  logic [7:0]      w_min;
  logic [7:0]      w_hour;
  logic            w_sec_wrap;
  logic            w_min_wrap;
  logic            w_hour_wrap;

  assign w_any_ld = hour_ld | min_ld | sec_ld;
  assign w_en     = CTT & CTP & ~w_any_ld;
  assign w_step   = w_en && (r_ps == PS_W'(CLK_DIV - 1));
  assign w_up     = w_step & ~dir;
  assign w_dn     = w_step & dir;

  // Seconds prescaler: free-runs while enabled, restarts on any field load.
  always_ff @(posedge clk1) begin
    if (!rst_n || w_any_ld) r_ps <= '0;
    else if (w_en)          r_ps <= w_step ? '0 : r_ps + 1'b1;
  end

  bcd_mod_counter #(.MAX(SEC_MAX)) u_sec (
    .clk1(clk1), .rst_n(rst_n),
    .inc(w_up), .dec(w_dn),
    .ld(sec_ld), .ld_val(sec_in),
    .value(w_sec), .wrap(w_sec_wrap)
  );

  bcd_mod_counter #(.MAX(MIN_MAX)) u_min (
    .clk1(clk1), .rst_n(rst_n),
    .inc(w_up & w_sec_wrap), .dec(w_dn & w_sec_wrap),
    .ld(min_ld), .ld_val(min_in),
    .value(w_min), .wrap(w_min_wrap)
  );

  bcd_mod_counter #(.MAX(HOUR_MAX)) u_hour (
    .clk1(clk1), .rst_n(rst_n),
    .inc(w_up & w_min_wrap), .dec(w_dn & w_min_wrap),
    .ld(hour_ld), .ld_val(hour_in),
    .value(w_hour), .wrap(w_hour_wrap)
  );

  // Registered one-cycle pulses for the second advance and the day wrap.
  always_ff @(posedge clk1) begin
    if (!rst_n) begin
      r_tick      <= 1'b0;
      r_day_carry <= 1'b0;
    end else begin
      r_tick      <= w_step;
      r_day_carry <= w_hour_wrap;
    end
  end

  assign tick      = r_tick;
  assign day_carry = r_day_carry;
  assign pm        = (w_hour >= HOUR_NOON);
  assign num       = {(mode_12h ? hour_to_12h(w_hour) : w_hour), w_min, w_sec};

`ifdef RTC_ALARM_EN
  logic [23:0] r_alarm;
  logic        r_alarm_o;
  logic        w_alarm_hit;

  // Alarm compare value, each field validated like the time loads.
  always_ff @(posedge clk1) begin
    if (!rst_n) begin
      r_alarm <= '0;
    end else if (alarm_set) begin
      r_alarm <= {(bcd_valid(alarm_in[23:16], HOUR_MAX) ? alarm_in[23:16] : 8'h00),
                  (bcd_valid(alarm_in[15:8],  MIN_MAX)  ? alarm_in[15:8]  : 8'h00),
                  (bcd_valid(alarm_in[7:0],   SEC_MAX)  ? alarm_in[7:0]   : 8'h00)};
    end
  end

  // Only a counted second (tick high) can match, so loads never fire it.
  assign w_alarm_hit = r_tick && alarm_arm && ({w_hour, w_min, w_sec} == r_alarm);

  // Sticky alarm flag: set wins over ack; disarming clears it.
  always_ff @(posedge clk1) begin
    if (!rst_n)                        r_alarm_o <= 1'b0;
    else if (w_alarm_hit)              r_alarm_o <= 1'b1;
    else if (alarm_ack || !alarm_arm)  r_alarm_o <= 1'b0;
  end

  assign alarm_o = r_alarm_o;
`endif

endmodule

// File: tb/tb_bcd_rtc_core.sv
// Self-checking bench for bcd_rtc_core (CLK_DIV=4): directed steps followed
// by a randomized phase, all checked against a seconds-of-day reference model.
// Alarm checks are compiled when RTC_ALARM_EN is defined.
module tb_bcd_rtc_core;

  localparam int CLK_DIV = 4;
  localparam int PS_W    = 3;
  localparam int DAY     = 86400;

  logic        clk1 = 1'b0;
  logic        rst_n, CTT, CTP, dir, mode_12h;
  logic [7:0]  hour_in, min_in, sec_in;
  logic        hour_ld, min_ld, sec_ld;
  logic [23:0] num;
  logic        pm, tick, day_carry;
`ifdef RTC_ALARM_EN
  logic [23:0] alarm_in;
  logic        alarm_set, alarm_arm, alarm_ack, alarm_o;
`endif

  always #5 clk1 = ~clk1;

  bcd_rtc_core #(.CLK_DIV(CLK_DIV), .PS_W(PS_W)) dut (
    .clk1(clk1), .rst_n(rst_n), .CTT(CTT), .CTP(CTP), .dir(dir),
    .mode_12h(mode_12h), .hour_in(hour_in), .min_in(min_in), .sec_in(sec_in),
    .hour_ld(hour_ld), .min_ld(min_ld), .sec_ld(sec_ld),
`ifdef RTC_ALARM_EN
    .alarm_in(alarm_in), .alarm_set(alarm_set), .alarm_arm(alarm_arm),
    .alarm_ack(alarm_ack), .alarm_o(alarm_o),
`endif
    .num(num), .pm(pm), .tick(tick), .day_carry(day_carry)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: time of day as plain seconds, prescaler as an integer.
  int   m_secs, m_ps;
  logic m_tick, m_day;
`ifdef RTC_ALARM_EN
  int   m_alarm;
  logic m_alarm_o;
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Decimal value of a BCD field, or 0 when it is not a legal value <= lim.
  function automatic int field_val(input logic [7:0] v, input int lim);
    int t, o, x;
    t = int'(v[7:4]);
    o = int'(v[3:0]);
    if (t > 9 || o > 9) return 0;
    x = t * 10 + o;
    return (x > lim) ? 0 : x;
  endfunction

  function automatic logic [7:0] to_bcd(input int x);
    return 8'((x / 10) * 16 + (x % 10));
  endfunction

  function automatic logic [23:0] model_num();
    int h, mi, s, hd;
    h  = m_secs / 3600;
    mi = (m_secs / 60) % 60;
    s  = m_secs % 60;
    hd = h;
    if (mode_12h) begin
      if (h == 0)      hd = 12;
      else if (h > 12) hd = h - 12;
    end
    return {to_bcd(hd), to_bcd(mi), to_bcd(s)};
  endfunction

  task automatic model_update();
    int h, mi, s;
`ifdef RTC_ALARM_EN
    if (!rst_n)                                         m_alarm_o = 1'b0;
    else if (m_tick && alarm_arm && m_secs == m_alarm)  m_alarm_o = 1'b1;
    else if (alarm_ack || !alarm_arm)                   m_alarm_o = 1'b0;
    if (!rst_n) m_alarm = 0;
    else if (alarm_set)
      m_alarm = field_val(alarm_in[23:16], 23) * 3600 +
                field_val(alarm_in[15:8], 59) * 60 + field_val(alarm_in[7:0], 59);
`endif
    if (!rst_n) begin
      m_secs = 0; m_ps = 0; m_tick = 1'b0; m_day = 1'b0;
    end else if (hour_ld || min_ld || sec_ld) begin
      h  = m_secs / 3600;
      mi = (m_secs / 60) % 60;
      s  = m_secs % 60;
      if (hour_ld) h  = field_val(hour_in, 23);
      if (min_ld)  mi = field_val(min_in, 59);
      if (sec_ld)  s  = field_val(sec_in, 59);
      m_secs = h * 3600 + mi * 60 + s;
      m_ps = 0; m_tick = 1'b0; m_day = 1'b0;
    end else if (CTT && CTP) begin
      if (m_ps == CLK_DIV - 1) begin
        m_ps = 0;
        m_tick = 1'b1;
        if (dir) begin
          m_day  = (m_secs == 0);
          m_secs = (m_secs + DAY - 1) % DAY;
        end else begin
          m_day  = (m_secs == DAY - 1);
          m_secs = (m_secs + 1) % DAY;
        end
      end else begin
        m_ps++; m_tick = 1'b0; m_day = 1'b0;
      end
    end else begin
      m_tick = 1'b0; m_day = 1'b0;
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".num"},  32'(num),       32'(model_num()));
    check({tag, ".pm"},   32'(pm),        32'((m_secs / 3600) >= 12));
    check({tag, ".tick"}, 32'(tick),      32'(m_tick));
    check({tag, ".day"},  32'(day_carry), 32'(m_day));
`ifdef RTC_ALARM_EN
    check({tag, ".alarm"}, 32'(alarm_o), 32'(m_alarm_o));
`endif
  endtask

  // One clock: model follows the edge, outputs sampled 1 time unit later.
  task automatic cycle(input string tag);
    @(posedge clk1);
    model_update();
    #1;
    check_all(tag);
  endtask

  task automatic load_all(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
    hour_in = h; min_in = m; sec_in = s;
    hour_ld = 1'b1; min_ld = 1'b1; sec_ld = 1'b1;
  endtask

  task automatic clear_ld();
    hour_ld = 1'b0; min_ld = 1'b0; sec_ld = 1'b0;
  endtask

  initial begin
    logic [23:0] frozen;
    int ps_before, n;

    rst_n = 1'b0; CTT = 1'b1; CTP = 1'b1; dir = 1'b0; mode_12h = 1'b0;
    hour_in = 8'h00; min_in = 8'h00; sec_in = 8'h00;
    clear_ld();
`ifdef RTC_ALARM_EN
    alarm_in = '0; alarm_set = 1'b0; alarm_arm = 1'b0; alarm_ack = 1'b0;
`endif

    // 1. Reset held for two cycles with counting enabled.
    for (int i = 0; i < 2; i++) begin
      cycle("reset");
      check("reset.num_const", 32'(num), 32'h000000);
    end
    rst_n = 1'b1;

    // 2. Up wrap from 23:59:58.
    load_all(8'h23, 8'h59, 8'h58);
    for (int i = 0; i < 3; i++) cycle("upwrap.load");
    clear_ld();
    for (int i = 0; i < 4; i++) cycle("upwrap.run");
    check("upwrap.235959", 32'(num), 32'h235959);
    for (int i = 0; i < 4; i++) cycle("upwrap.run");
    check("upwrap.midnight", 32'(num), 32'h000000);
    check("upwrap.tick", 32'(tick), 32'd1);
    check("upwrap.day_carry", 32'(day_carry), 32'd1);
    cycle("upwrap.after");
    check("upwrap.day_pulse_len", 32'(day_carry), 32'd0);

    // 3. Enable gating: CTP low freezes everything.
    ps_before = m_ps;
    frozen = model_num();
    CTP = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cycle("gate.off");
      check("gate.frozen", 32'(num), 32'(frozen));
    end
    CTP = 1'b1;
    n = 0;
    do begin
      cycle("gate.on");
      n++;
    end while (tick !== 1'b1 && n < 12);
    check("gate.latency", 32'(n), 32'(CLK_DIV - ps_before));

    // 4. Load validation with counting disabled.
    CTT = 1'b0;
    load_all(8'h12, 8'h34, 8'h56);
    cycle("valid.base");
    clear_ld();
    min_in = 8'h6A; min_ld = 1'b1;
    cycle("valid.min");
    check("valid.min_6A", 32'(num), 32'h120056);
    clear_ld();
    hour_in = 8'h24; hour_ld = 1'b1;
    cycle("valid.hour");
    check("valid.hour_24", 32'(num), 32'h000056);
    clear_ld();
    sec_in = 8'h59; sec_ld = 1'b1;
    cycle("valid.sec");
    check("valid.sec_59", 32'(num), 32'h000059);
    clear_ld();

    // 5. 12-hour display formatting.
    mode_12h = 1'b1;
    load_all(8'h13, 8'h05, 8'h00);
    cycle("h12.pm");
    check("h12.1305", 32'(num), 32'h010500);
    check("h12.pm_flag", 32'(pm), 32'd1);
    load_all(8'h00, 8'h30, 8'h00);
    cycle("h12.midnight");
    check("h12.0030", 32'(num), 32'h123000);
    check("h12.am_flag", 32'(pm), 32'd0);
    clear_ld();
    mode_12h = 1'b0;
    cycle("h12.off");
    check("h12.24h_back", 32'(num), 32'h003000);

    // 6. Down wrap from 00:00:00 (load beats count while enables are high).
    CTT = 1'b1; CTP = 1'b1; dir = 1'b1;
    load_all(8'h00, 8'h00, 8'h00);
`ifdef RTC_ALARM_EN
    alarm_in = 24'h235958; alarm_set = 1'b1; alarm_arm = 1'b1;
`endif
    cycle("down.load");
    clear_ld();
`ifdef RTC_ALARM_EN
    alarm_set = 1'b0;
`endif
    for (int i = 0; i < 4; i++) cycle("down.run");
    check("down.235959", 32'(num), 32'h235959);
    check("down.day_carry", 32'(day_carry), 32'd1);
    for (int i = 0; i < 4; i++) cycle("down.run");
    check("down.235958", 32'(num), 32'h235958);
`ifdef RTC_ALARM_EN
    check("alarm.not_yet", 32'(alarm_o), 32'd0);
    cycle("alarm.rise");
    check("alarm.set", 32'(alarm_o), 32'd1);
    cycle("alarm.hold");
    check("alarm.sticky", 32'(alarm_o), 32'd1);
    alarm_ack = 1'b1;
    cycle("alarm.ack");
    check("alarm.cleared", 32'(alarm_o), 32'd0);
    alarm_ack = 1'b0;
`endif

    // Randomized phase against the model.
    for (int i = 0; i < 3000; i++) begin
      rst_n = ($urandom_range(0, 199) != 0);
      CTT   = ($urandom_range(0, 9) != 0);
      CTP   = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 49) == 0) dir = ~dir;
      if ($urandom_range(0, 19) == 0) mode_12h = ~mode_12h;
      hour_ld = ($urandom_range(0, 39) == 0);
      min_ld  = ($urandom_range(0, 39) == 0);
      sec_ld  = ($urandom_range(0, 39) == 0);
      hour_in = $urandom_range(0, 1) ? to_bcd($urandom_range(0, 23)) : 8'($urandom_range(0, 255));
      min_in  = $urandom_range(0, 1) ? to_bcd($urandom_range(0, 59)) : 8'($urandom_range(0, 255));
      sec_in  = $urandom_range(0, 1) ? to_bcd($urandom_range(0, 59)) : 8'($urandom_range(0, 255));
`ifdef RTC_ALARM_EN
      alarm_set = ($urandom_range(0, 49) == 0);
      begin
        int t;
        t = (m_secs + (dir ? DAY - 3 : 3)) % DAY;
        alarm_in = {to_bcd(t / 3600), to_bcd((t / 60) % 60), to_bcd(t % 60)};
      end
      alarm_arm = ($urandom_range(0, 29) != 0);
      alarm_ack = ($urandom_range(0, 19) == 0);
`endif
      cycle("rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/bcd_rtc_core.md
Name: bcd_rtc_core

Overview:
- Parametrised successor to the MyClock time counter: a BCD hours/minutes/seconds real-time core with an internal seconds prescaler.
- Adds up/down counting, a 12/24-hour display mode, field-load validation and a day-carry pulse.
- Sits between the board clock and the display/segment driver; `num` feeds `disp_num` formatting upstream.

Parameters:
- CLK_DIV, 50000000, clk1 cycles per second tick (≥2; bench uses 4).
- PS_W, 26, prescaler width; must satisfy 2^PS_W ≥ CLK_DIV.

Ports:
- clk1  in  1  system clock; all logic on rising edge.
- rst_n  in  1  synchronous active-low reset.
- CTT  in  1  count enable T; counting requires CTT & CTP.
- CTP  in  1  count enable P.
- dir  in  1  0 = count up, 1 = count down.
- mode_12h  in  1  1 = 12-hour display on num, 0 = 24-hour.
- hour_in  in  8  BCD hour load value, always 24-hour format.
- min_in  in  8  BCD minute load value.
- sec_in  in  8  BCD second load value.
- hour_ld  in  1  load hour field.
- min_ld  in  1  load minute field.
- sec_ld  in  1  load second field.
- num  out  24  {hour, min, sec} BCD, display-formatted.
- pm  out  1  1 when internal hour ≥ 12 (valid in both modes).
- tick  out  1  one-cycle pulse on each second advance.
- day_carry  out  1  one-cycle pulse on 23:59:59↔00:00:00 wrap, either direction.

Behaviour:
- Reset (rst_n=0 at edge): prescaler, hour, min and sec registers are 0; tick=0, day_carry=0, pm=0; num=0x000000, or 0x120000 if mode_12h=1.
- Enable: en = CTT & CTP & ~(hour_ld | min_ld | sec_ld).
- Prescaler: counts 0..CLK_DIV-1 while en; holds when en=0; clears to 0 on any *_ld.
- tick is registered, high the cycle after the edge where the prescaler wraps. The time registers update on that same edge.
- Up count: sec 00..59 → min → hour 00..23.
- Down count: sec borrows from min, min borrows from hour; 00:00:00 → 23:59:59.
- day_carry: registered, coincident with the tick that performs the day wrap.
- Load priority: load beats count. Each asserted *_ld loads its field at the edge. Unloaded fields hold; no tick that cycle. A held load reloads every cycle.
- Validation, applied per field at load:
  - Each nibble must be ≤9.
  - sec and min must be ≤0x59; hour must be ≤0x23.
  - An invalid value loads 0x00.
- Internal hour is always 24-hour. 12-hour formatting on num is combinational from the registers:
  - internal 00 → 12
  - 01–12 → unchanged
  - 13–23 → value − 12, in BCD
- Changing mode_12h mid-run changes only num formatting; it never alters registers or timing.
- Changing dir mid-run takes effect at the next tick; no glitch on current fields.
- Reset mid-count returns everything to reset values on that edge regardless of *_ld.

Optional Feature:
- Macro: RTC_ALARM_EN.
- Defined: adds ports
  - alarm_in (in, 24): BCD 24-hour alarm value, validated like the field loads.
  - alarm_set (in, 1): loads alarm_in into the alarm register.
  - alarm_arm (in, 1): arms the alarm.
  - alarm_ack (in, 1): clears alarm_o.
  - alarm_o (out, 1): sticky alarm flag.
- alarm_o sets on the edge after a tick that makes the internal time equal the alarm register while alarm_arm=1.
- alarm_o clears on alarm_ack=1 or alarm_arm=0; set wins over ack in the same cycle.
- Loads never trigger the alarm.
- Alarm register and alarm_o reset to 0.
- Undefined: none of these ports or registers exist; all other behaviour is identical.

Decomposition:
- Package rtc_pkg: BCD limit constants SEC_MAX=8'h59, MIN_MAX=8'h59, HOUR_MAX=8'h23, HOUR_NOON=8'h12; BCD validity function; 24→12-hour conversion function.
- Sub-module bcd_mod_counter:
  - Parameter MAX: 2-digit BCD counter.
  - Inputs: inc, dec, ld and ld_val.
  - Outputs: value, and wrap (combinational, asserted when the next inc or dec wraps).
  - Instantiated three times and chained by wrap.

Test Plan (CLK_DIV=4):
1. Reset: rst_n=0 for 2 cycles with CTT=CTP=1, mode_12h=0 → num=0x000000, tick=0, day_carry=0 throughout.
2. Up wrap: load 23:59:58 for 3 cycles, then ld=0 with CTT=CTP=1, dir=0.
   - 4 cycles later num=0x235959.
   - 4 more cycles later num=0x000000 with tick=1 and day_carry=1 for exactly that one cycle.
3. Enable gating: CTT=1, CTP=0 for 20 cycles → num frozen, tick=0. Restore CTP=1 → next tick exactly 4 − (prior prescaler count) cycles later.
4. Validation: min_in=0x6A with min_ld=1 → min=0x00. Separately, hour_in=0x24 → hour=0x00; sec_in=0x59 → accepted.
5. 12-hour mode:
   - Load 13:05:00, mode_12h=1 → num=0x010500, pm=1.
   - Load 00:30:00 → num=0x123000, pm=0.
   - Toggle mode_12h=0 → num=0x003000 with no register change.
6. Down wrap: load 00:00:00, dir=1, enables high → after first tick num=0x235959 and day_carry=1. With RTC_ALARM_EN, alarm at 23:59:58 armed → alarm_o rises after the next tick and stays high until alarm_ack.
